// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default sizing for the memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    localparam int DEF_ADDR_W       = 64;
    localparam int DEF_DATA_W       = 64;
    localparam int DEF_RESP_TIMEOUT = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant logic for the memory port; MEM_ARB_RR_EN selects round-robin,
// otherwise the LSU always wins a collision.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic if_valid,
    input  logic ls_valid,
`ifdef MEM_ARB_RR_EN
    input  logic rr_last,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = if_valid || ls_valid;
`ifdef MEM_ARB_RR_EN
        // on a collision the requester that did not own the last transaction goes first
        if (if_valid && ls_valid) begin
            grant_owner = (rr_last == OWN_LS) ? OWN_IF : OWN_LS;
        end else begin
            grant_owner = ls_valid ? OWN_LS : OWN_IF;
        end
`else
        grant_owner = ls_valid ? OWN_LS : OWN_IF;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between IFU fetches and LSU loads/stores, one
// transaction at a time, with a response timeout. MEM_ARB_RR_EN enables round-robin.
//
// state | meaning
// IDLE  | no transaction; arbitrate and accept one requester
// REQ   | request presented to memory, waiting for mem_req_ready
// RESP  | waiting for mem_rvalid or the response timeout
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    output logic                if_resp_err,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_data,
    output logic                ls_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int               CNT_W    = $clog2(RESP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    arb_state_e        state;
    arb_owner_e        owner;
    logic [CNT_W-1:0]  resp_cnt;
    logic              drop_if;
    logic              grant_valid;
    logic              grant_owner;
    logic              flush_hit;
    logic [DATA_W-1:0] resp_data_c;
`ifdef MEM_ARB_RR_EN
    arb_owner_e        rr_last;
`endif

    mem_arb_pick u_pick (
        .if_valid    (if_req_valid),
        .ls_valid    (ls_req_valid),
`ifdef MEM_ARB_RR_EN
        .rr_last     (rr_last),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // readies are combinational but must still read 0 while reset is held
    assign if_req_ready = !rst && (state == IDLE) && grant_valid && (grant_owner == OWN_IF);
    assign ls_req_ready = !rst && (state == IDLE) && grant_valid && (grant_owner == OWN_LS);

    assign flush_hit   = if_flush && (owner == OWN_IF);
    assign resp_data_c = (mem_rvalid && !mem_wen) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            resp_cnt      <= '0;
            drop_if       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            if_resp_err   <= 1'b0;
            ls_resp_valid <= 1'b0;
            ls_resp_data  <= '0;
            ls_resp_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_last       <= OWN_IF;
`endif
        end else begin
            if_resp_valid <= 1'b0;
            if_resp_err   <= 1'b0;
            ls_resp_valid <= 1'b0;
            ls_resp_err   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state         <= REQ;
                        owner         <= arb_owner_e'(grant_owner);
                        mem_req_valid <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        rr_last       <= arb_owner_e'(grant_owner);
`endif
                        if (grant_owner == OWN_LS) begin
                            mem_addr  <= ls_addr;
                            mem_wen   <= ls_wen;
                            mem_wdata <= ls_wdata;
                            mem_wmask <= ls_wmask;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                    end
                end

                REQ: begin
                    if (flush_hit) drop_if <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        resp_cnt      <= '0;
                        state         <= RESP;
                    end
                end

                RESP: begin
                    if (flush_hit) drop_if <= 1'b1;
                    // a response in the last counted cycle still beats the timeout
                    if (mem_rvalid || (resp_cnt == CNT_LAST)) begin
                        state   <= IDLE;
                        drop_if <= 1'b0;
                        if (owner == OWN_LS) begin
                            ls_resp_valid <= 1'b1;
                            ls_resp_data  <= resp_data_c;
                            ls_resp_err   <= !mem_rvalid;
                        end else if (!drop_if && !flush_hit) begin
                            if_resp_valid <= 1'b1;
                            if_resp_data  <= resp_data_c;
                            if_resp_err   <= !mem_rvalid;
                        end
                    end else begin
                        resp_cnt <= resp_cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory model answers requests,
// expected requests/responses are queued as stimulus is driven.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic        own;
        logic [63:0] data;
        logic        err;
        int          lat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_flush;
    logic [63:0] if_addr;
    logic        if_resp_valid, if_resp_err;
    logic [63:0] if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_wen;
    logic [63:0] ls_addr, ls_wdata;
    logic [7:0]  ls_wmask;
    logic        ls_resp_valid, ls_resp_err;
    logic [63:0] ls_resp_data;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic [271:0] all_outs;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int if_strobes = 0;
    int ls_strobes = 0;
    int cfg_stall = 0;
    int cfg_rdelay = 0;
    int cfg_late = 0;
    logic cfg_drop = 1'b0;
    logic last_own = 1'b0;
    logic [63:0] exp_last_if = '0;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    req_t if_pend[$];
    req_t ls_pend[$];

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RESP_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .if_resp_err(if_resp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    assign all_outs = {if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
                       ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
                       mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rdata_of(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h1122_3344_5566_7788;
        return {~a[31:0], a[31:0]};
    endfunction

    function automatic req_t mk_req(input logic [63:0] a, input logic w,
                                    input logic [63:0] d, input logic [7:0] m);
        req_t r;
        r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
        return r;
    endfunction

    task automatic push_exp(input req_t r, input logic own);
        rsp_t e;
        exp_req_q.push_back(r);
        e.own  = own;
        e.err  = cfg_drop;
        e.data = (cfg_drop || r.wen) ? 64'h0 : rdata_of(r.addr);
        e.lat  = cfg_drop ? TO + 1 : cfg_rdelay + 2;
        exp_rsp_q.push_back(e);
        if (!own) exp_last_if = e.data;
    endtask

    // predicts grant order for all pending requests, then drives them until drained
    task automatic run_batch();
        int ii = 0;
        int il = 0;
        int guard = 0;
        while (ii < if_pend.size() || il < ls_pend.size()) begin
            logic pick_ls;
            if (ii < if_pend.size() && il < ls_pend.size()) begin
`ifdef MEM_ARB_RR_EN
                pick_ls = (last_own == 1'b0);
`else
                pick_ls = 1'b1;
`endif
            end else begin
                pick_ls = (il < ls_pend.size());
            end
            if (pick_ls) begin push_exp(ls_pend[il], 1'b1); il++; end
            else begin push_exp(if_pend[ii], 1'b0); ii++; end
            last_own = pick_ls;
        end
        while ((if_pend.size() > 0 || ls_pend.size() > 0 || exp_rsp_q.size() > 0) && guard < 400) begin
            @(posedge clk); #1;
            if_req_valid = (if_pend.size() > 0);
            if (if_pend.size() > 0) if_addr = if_pend[0].addr;
            ls_req_valid = (ls_pend.size() > 0);
            if (ls_pend.size() > 0) begin
                ls_addr = ls_pend[0].addr; ls_wen = ls_pend[0].wen;
                ls_wdata = ls_pend[0].wdata; ls_wmask = ls_pend[0].wmask;
            end
            @(negedge clk);
            if (if_req_valid && if_req_ready) if_pend.delete(0);
            if (ls_req_valid && ls_req_ready) ls_pend.delete(0);
            guard++;
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        chk("batch_drain", if_pend.size() + ls_pend.size() + exp_rsp_q.size(), 0);
        if_pend.delete(); ls_pend.delete(); exp_rsp_q.delete();
    endtask

    initial begin : mem_model
        int ph = 0;
        int cnt = 0;
        req_t cur;
        cur = mk_req(64'h0, 1'b0, 64'h0, 8'h0);
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            mem_rvalid = 1'b0;
            if (rst) begin
                ph = 0;
            end else begin
                if (ph == 0 && mem_req_valid) begin ph = 1; cnt = 0; end
                if (ph == 1) begin
                    if (exp_req_q.size() == 0) begin
                        chk("req_unexpected", mem_req_valid, 1'b0);
                        ph = 0;
                    end else begin
                        cur = exp_req_q[0];
                        chk("req_fields", {mem_req_valid, mem_addr, mem_wen, mem_wmask},
                            {1'b1, cur.addr, cur.wen, cur.wmask});
                        if (cur.wen) chk("req_wdata", mem_wdata, cur.wdata);
                        if (cnt == cfg_stall) begin
                            mem_req_ready = 1'b1;
                            hs_cyc = cyc;
                            exp_req_q.delete(0);
                            ph = 2; cnt = 0;
                        end else cnt++;
                    end
                end else if (ph == 2) begin
                    if (cfg_drop ? (cnt == TO + cfg_late - 1) : (cnt == cfg_rdelay)) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = rdata_of(cur.addr);
                        ph = 0;
                    end else cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (if_req_ready || ls_req_ready) chk("ready_excl", if_req_ready & ls_req_ready, 0);
            if (if_resp_valid) if_strobes++;
            if (ls_resp_valid) ls_strobes++;
            if (if_resp_valid || ls_resp_valid) begin
                chk("rsp_single", if_resp_valid & ls_resp_valid, 0);
                if (exp_rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {if_resp_valid, ls_resp_valid}, 0);
                end else begin
                    rsp_t r;
                    r = exp_rsp_q.pop_front();
                    chk("rsp_owner", ls_resp_valid, r.own);
                    chk("rsp_data", r.own ? ls_resp_data : if_resp_data, r.data);
                    chk("rsp_err", r.own ? ls_resp_err : if_resp_err, r.err);
                    chk("rsp_latency", cyc - hs_cyc, r.lat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        if_req_valid = 0; if_addr = '0; if_flush = 0;
        ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs, '0);
        @(posedge clk); #1 rst = 1'b0;

        // single IFU read, minimum latency
        push_exp(mk_req(64'h8000_0000, 1'b0, 64'h0, 8'h00), 1'b0);
        last_own = 1'b0;
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 64'h8000_0000;
        @(negedge clk);
        chk("t1_if_ready", if_req_ready, 1'b1);
        chk("t1_ls_ready", ls_req_ready, 1'b0);
        @(posedge clk); #1 if_req_valid = 1'b0;
        @(negedge clk) chk("t1_mem_req_valid", mem_req_valid, 1'b1);
        @(negedge clk) chk("t1_no_early_rsp", if_resp_valid, 1'b0);
        @(negedge clk) chk("t1_rsp_cycle3", if_resp_valid, 1'b1);
        @(negedge clk) chk("t1_rsp_one_cycle", if_resp_valid, 1'b0);

        // collision: IFU read vs LSU store
        if_pend.push_back(mk_req(64'h8000_0000, 1'b0, 64'h0, 8'h00));
        ls_pend.push_back(mk_req(64'h8000_1000, 1'b1, {8{8'hAB}}, 8'h01));
        run_batch();

        // sustained collision, four grants
        if_pend.push_back(mk_req(64'h8000_0100, 1'b0, 64'h0, 8'h00));
        if_pend.push_back(mk_req(64'h8000_0108, 1'b0, 64'h0, 8'h00));
        ls_pend.push_back(mk_req(64'h8000_1010, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0));
        ls_pend.push_back(mk_req(64'h8000_1018, 1'b0, 64'h0, 8'h00));
        run_batch();

        // memory stalls the request 5 cycles
        cfg_stall = 5; cfg_rdelay = 1;
        ls_pend.push_back(mk_req(64'h8000_2000, 1'b0, 64'h0, 8'h00));
        run_batch();
        cfg_stall = 0; cfg_rdelay = 0;

        // response timeout, late rvalid must not strobe
        cfg_drop = 1'b1; cfg_late = 3;
        n = ls_strobes;
        ls_pend.push_back(mk_req(64'h8000_3000, 1'b0, 64'h0, 8'h00));
        run_batch();
        repeat (12) @(negedge clk);
        chk("t5_single_strobe", ls_strobes - n, 1);
        cfg_drop = 1'b0; cfg_late = 0;

        // flush during RESP drops the IFU response
        cfg_rdelay = 2;
        exp_req_q.push_back(mk_req(64'h8000_0200, 1'b0, 64'h0, 8'h00));
        n = if_strobes;
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 64'h8000_0200;
        @(negedge clk) chk("t6_ready", if_req_ready, 1'b1);
        @(posedge clk); #1 if_req_valid = 1'b0;
        @(posedge clk); #1 if_flush = 1'b1;
        @(posedge clk); #1 if_flush = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_no_if_strobe", if_strobes - n, 0);
        chk("t6_data_held", if_resp_data, exp_last_if);
        cfg_rdelay = 0;
        last_own = 1'b0;

        // flush while idle does not block acceptance or the response
        push_exp(mk_req(64'h8000_0208, 1'b0, 64'h0, 8'h00), 1'b0);
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 64'h8000_0208; if_flush = 1'b1;
        @(negedge clk) chk("t6b_ready_with_flush", if_req_ready, 1'b1);
        @(posedge clk); #1 if_req_valid = 1'b0; if_flush = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6b_rsp_drained", exp_rsp_q.size(), 0);

        // reset mid-REQ clears every output asynchronously
        cfg_stall = 10;
        exp_req_q.push_back(mk_req(64'h8000_4000, 1'b1, 64'h5555_AAAA_5555_AAAA, 8'h0F));
        @(posedge clk); #1;
        ls_req_valid = 1'b1; ls_addr = 64'h8000_4000; ls_wen = 1'b1;
        ls_wdata = 64'h5555_AAAA_5555_AAAA; ls_wmask = 8'h0F;
        @(negedge clk) chk("t7_ready", ls_req_ready, 1'b1);
        @(posedge clk); #1 ls_req_valid = 1'b0; ls_wen = 1'b0;
        @(posedge clk);
        @(negedge clk) chk("t7_in_req", mem_req_valid, 1'b1);
        #2;
        rst = 1'b1; if_req_valid = 1'b1;
        exp_req_q.delete(); exp_rsp_q.delete();
        #1 chk("t7_async_reset", all_outs, '0);
        @(posedge clk); #1 if_req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        cfg_stall = 0; last_own = 1'b0; exp_last_if = '0;

        // collision straight after reset
        if_pend.push_back(mk_req(64'h8000_0300, 1'b0, 64'h0, 8'h00));
        ls_pend.push_back(mk_req(64'h8000_1300, 1'b0, 64'h0, 8'h00));
        run_batch();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (pmem path) between the instruction fetch requester (IFU, read-only) and the load/store requester (LSU, MEM stage).
- Accepts one transaction at a time, drives the memory request handshake and waits for the response.
- Routes the response back to the owner; a timeout error closes any response that never arrives.

Parameters:
- ADDR_W, 64, request address width.
- DATA_W, 64, data width; the byte mask is DATA_W/8 bits.
- RESP_TIMEOUT, 255, maximum cycles in RESP before a forced error response; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req_valid  in  1  IFU read request
- if_req_ready  out  1  IFU request accepted this cycle
- if_addr  in  ADDR_W  IFU address
- if_flush  in  1  drop any pending IFU response
- if_resp_valid  out  1  IFU response strobe
- if_resp_data  out  DATA_W  IFU read data
- if_resp_err  out  1  IFU timeout error
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted
- ls_addr  in  ADDR_W  LSU address
- ls_wen  in  1  1 = store
- ls_wdata  in  DATA_W  store data, lane-replicated
- ls_wmask  in  DATA_W/8  byte mask
- ls_resp_valid  out  1  LSU response strobe
- ls_resp_data  out  DATA_W  LSU read data, zero for stores
- ls_resp_err  out  1  LSU timeout error
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W
- mem_wen  out  1
- mem_wdata  out  DATA_W
- mem_wmask  out  DATA_W/8  all zero for reads
- mem_rvalid  in  1  memory response; required for stores too
- mem_rdata  in  DATA_W

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: FSM is IDLE; owner=IFU; timeout counter=0; rr pointer=IFU.
- Reset values of outputs: every output is 0.
- A reset asserted mid-transaction abandons the transaction immediately. No response is issued.
- FSM states are IDLE, REQ and RESP.
- IDLE:
  - Arbitrate between valid requesters; the default priority is LSU over IFU.
  - The winner's x_req_ready is asserted combinationally in the same cycle. Only one ready is ever high.
  - On acceptance, latch addr, wen, wdata, wmask and owner. IFU requests latch wen=0 and wmask=0.
  - Next state: REQ.
  - Ready outputs are 0 in every other state.
- REQ:
  - mem_req_valid=1 with the latched fields held stable.
  - On mem_req_ready, go to RESP and clear the counter.
- RESP:
  - The counter increments each cycle.
  - On mem_rvalid, register mem_rdata into the owner's resp_data (0 for stores), pulse the owner's resp_valid for exactly 1 cycle with err=0, and return to IDLE.
  - If the counter reaches RESP_TIMEOUT first, pulse resp_valid with err=1 and data=0, and return to IDLE.
  - A mem_rvalid arriving after a timeout is ignored.
- Latency:
  - Request accepted in cycle 0, mem_req_valid in cycle 1.
  - With mem_req_ready in cycle 1 and mem_rvalid in cycle 2, resp_valid is high in cycle 3.
  - Minimum request-to-response latency is 3 cycles.
  - A new request can be accepted in the same cycle as resp_valid, since the FSM is IDLE then.
- if_flush:
  - Sets a sticky drop flag when the owner is IFU and the FSM is in REQ or RESP.
  - The memory transaction still completes, but if_resp_valid is suppressed. The flag clears on return to IDLE.
  - if_flush in IDLE has no effect on acceptance.
- Response data outputs hold their last value between strobes.
- mem_rvalid outside RESP is ignored.
- Stores are never cancelled once accepted. The LSU must gate ls_req_valid with its own flush.
- Simultaneous requests under fixed priority: LSU wins. IFU keeps if_req_valid high and waits.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous requests in IDLE, the requester that did not own the previous transaction wins.
  - The rr pointer updates on every acceptance.
- MEM_ARB_RR_EN undefined: fixed LSU-over-IFU priority; no pointer register is built.

Decomposition:
- Shared package/header entries:
  - state encodings: IDLE=2'd0, REQ=2'd1, RESP=2'd2
  - owner encoding: OWN_IF=1'b0, OWN_LS=1'b1
  - default widths
  - default RESP_TIMEOUT
- Sub-module mem_arb_pick: the combinational two-way grant logic, with fixed and round-robin variants under the macro.
- The FSM, request latch and timeout counter stay in the top module.

Test Plan:
- IFU read of addr 0x80000000, memory ready at once, rdata 0x1122334455667788 one cycle later -> if_resp_valid in cycle 3 with that data and err=0. mem_wmask=0x00 throughout.
- Simultaneous IFU read 0x80000000 and LSU store 0x80001000 (wdata 0xAB×8, wmask 0x01), without MEM_ARB_RR_EN -> store issued first and ls_resp_valid with data 0; the IFU read follows and completes.
- With MEM_ARB_RR_EN, the same collision for 4 back-to-back rounds -> grants alternate LS, IF, LS, IF.
- mem_req_ready held low 5 cycles, then high -> mem_req_valid and fields stable for 6 cycles; the response follows normally.
- RESP_TIMEOUT=4 and no mem_rvalid -> ls_resp_valid with err=1 and data 0 in cycle 4 of RESP. A late mem_rvalid causes no extra strobe.
- IFU read in progress, if_flush pulsed in RESP -> no if_resp_valid, FSM returns to IDLE. rst asserted mid-REQ -> all outputs 0 asynchronously.
